// File: rtl/counter_sequencer_pkg.sv
// Shared opcode constants and FSM state encoding for the counter sequencer.
package counter_sequencer_pkg;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_RUN_UP   = 2'b01;
    localparam logic [1:0] OP_RUN_DOWN = 2'b10;
    localparam logic [1:0] OP_CLEAR    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RUN_UP,
        RUN_DOWN,
        DONE,
        ABORT
    } state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command handshake bundle between the command source and the sequencer.
interface counter_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/counter_sequencer_jk_toggle_counter.sv
// Synchronous toggle counter datapath with load; bit i toggles when every
// lower bit is 1 (up) or 0 (down), the classic JK carry chain.
module jk_toggle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  logic             up,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] tog;

    // Toggle enables: AND of the lower bits (up) or of their complements (down)
    always_comb begin
        logic t;
        tog = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            t = 1'b1;
            for (int unsigned j = 0; j < i; j++) begin
                t = t & (up ? q[j] : ~q[j]);
            end
            tog[i] = t;
        end
    end

    // Counter register: reset, then load, then toggle-step
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= q ^ tog;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer that loads, clears or runs a toggle counter up or
// down to a programmable limit, reporting done/aborted as one-cycle pulses.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    counter_sequencer_if.slave  cmd,
    input  logic                en,
    input  logic                halt,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] next_cnt;
    logic             accept;
    logic             dp_load;
    logic             dp_step;
    logic             dp_up;
    logic [WIDTH-1:0] dp_load_val;

    // Datapath control and the count value after a step
    always_comb begin
        accept      = (state == IDLE) && cmd.cmd_valid;
        dp_up       = (state != RUN_DOWN);
        dp_step     = ((state == RUN_UP) || (state == RUN_DOWN)) && en && !halt;
        dp_load     = accept && ((cmd.cmd_op == OP_LOAD) || (cmd.cmd_op == OP_CLEAR));
        dp_load_val = (cmd.cmd_op == OP_CLEAR) ? '0 : cmd.cmd_data;
        next_cnt    = dp_up ? (count + ONE) : (count - ONE);
    end

    jk_toggle_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (dp_load),
        .load_val (dp_load_val),
        .step     (dp_step),
        .up       (dp_up),
        .q        (count)
    );

    // Sequencer FSM: halt beats both stepping and completion in run states
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            limit <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd.cmd_op)
                            OP_RUN_UP: begin
                                limit <= cmd.cmd_data;
                                state <= (cmd.cmd_data == count) ? DONE : RUN_UP;
                            end
                            OP_RUN_DOWN: begin
                                limit <= cmd.cmd_data;
                                state <= (cmd.cmd_data == count) ? DONE : RUN_DOWN;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                RUN_UP, RUN_DOWN: begin
                    if (halt) begin
                        state <= ABORT;
                    end else if (en && (next_cnt == limit)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state register only
    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state == RUN_UP) || (state == RUN_DOWN);
    assign done          = (state == DONE);
    assign aborted       = (state == ABORT);

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: table of run vectors plus
// hand-written sequences for pause, halt, reset mid-run and backpressure.
module tb_counter_sequencer;
    import counter_sequencer_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         halt;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         aborted;

    counter_sequencer_if #(.WIDTH(W)) cif ();

    counter_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cif.slave),
        .en      (en),
        .halt    (halt),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .aborted (aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] start;
        logic [1:0]   op;
        logic [W-1:0] lim;
        int           steps;
    } vec_t;

    vec_t         vecs[8];
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           busy_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Advance one cycle, sample 1ns after the edge, score any done pulse
    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
        if (done) begin
            if (exp_q.size() == 0) check("done_unexpected", int'(done), 0);
            else check("done_count", int'(count), int'(exp_q.pop_front()));
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] d);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = d;
        tick();
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_not_busy(input string name);
        int g = 0;
        while (busy && g < 40) begin
            tick();
            g++;
        end
        if (g >= 40) check({name, "_timeout"}, int'(busy), 0);
    endtask

    initial begin
        int g;
        vecs[0] = '{start: 4'd2,  op: OP_RUN_UP,   lim: 4'd5,  steps: 3};
        vecs[1] = '{start: 4'd1,  op: OP_RUN_DOWN, lim: 4'd14, steps: 3};
        vecs[2] = '{start: 4'd7,  op: OP_RUN_UP,   lim: 4'd7,  steps: 0};
        vecs[3] = '{start: 4'd14, op: OP_RUN_UP,   lim: 4'd1,  steps: 3};
        vecs[4] = '{start: 4'd3,  op: OP_RUN_DOWN, lim: 4'd2,  steps: 1};
        vecs[5] = '{start: 4'd0,  op: OP_RUN_UP,   lim: 4'd15, steps: 15};
        vecs[6] = '{start: 4'd9,  op: OP_RUN_DOWN, lim: 4'd9,  steps: 0};
        vecs[7] = '{start: 4'd5,  op: OP_RUN_DOWN, lim: 4'd6,  steps: 15};

        rst = 1'b1; en = 1'b1; halt = 1'b0;
        cif.cmd_valid = 1'b0; cif.cmd_op = OP_LOAD; cif.cmd_data = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_count",   int'(count),         0);
        check("rst_ready",   int'(cif.cmd_ready), 1);
        check("rst_busy",    int'(busy),          0);
        check("rst_done",    int'(done),          0);
        check("rst_aborted", int'(aborted),       0);

        // LOAD 9
        issue(OP_LOAD, 4'd9);
        check("load_count", int'(count), 9);
        check("load_busy",  int'(busy),  0);
        check("load_done",  int'(done),  0);

        // Up run 2 -> 5 with cycle-exact timing
        issue(OP_LOAD, 4'd2);
        exp_q.push_back(4'd5);
        issue(OP_RUN_UP, 4'd5);
        check("up_t1_busy", int'(busy), 1); check("up_t1_count", int'(count), 2);
        tick();
        check("up_t2_busy", int'(busy), 1); check("up_t2_count", int'(count), 3);
        tick();
        check("up_t3_busy", int'(busy), 1); check("up_t3_count", int'(count), 4);
        tick();
        check("up_t4_done", int'(done), 1); check("up_t4_busy", int'(busy), 0);
        check("up_t4_ready", int'(cif.cmd_ready), 0);
        tick();
        check("up_t5_ready", int'(cif.cmd_ready), 1); check("up_t5_done", int'(done), 0);

        // Table-driven runs, including wrap-around and zero-step cases
        foreach (vecs[k]) begin
            issue(OP_LOAD, vecs[k].start);
            busy_cnt = 0;
            exp_q.push_back(vecs[k].lim);
            issue(vecs[k].op, vecs[k].lim);
            wait_not_busy($sformatf("vec%0d", k));
            check($sformatf("vec%0d_busy_cycles", k), busy_cnt, vecs[k].steps);
            check($sformatf("vec%0d_done", k), int'(done), 1);
            check($sformatf("vec%0d_count", k), int'(count), int'(vecs[k].lim));
            tick();
            check($sformatf("vec%0d_ready", k), int'(cif.cmd_ready), 1);
        end

        // Pause: en low for two cycles mid-run
        issue(OP_LOAD, 4'd0);
        busy_cnt = 0;
        exp_q.push_back(4'd3);
        issue(OP_RUN_UP, 4'd3);
        tick();
        check("pause_pre_count", int'(count), 1);
        en = 1'b0;
        tick();
        tick();
        check("pause_hold_count", int'(count), 1);
        check("pause_hold_busy",  int'(busy),  1);
        en = 1'b1;
        wait_not_busy("pause");
        check("pause_busy_cycles", busy_cnt, 5);
        check("pause_done", int'(done), 1);
        tick();

        // Halt at count 9 beats completion at limit 10
        issue(OP_LOAD, 4'd0);
        issue(OP_RUN_UP, 4'd10);
        g = 0;
        while (count != 4'd9 && g < 40) begin
            tick();
            g++;
        end
        if (g >= 40) check("halt_timeout", int'(count), 9);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_aborted", int'(aborted), 1);
        check("halt_count",   int'(count),   9);
        check("halt_done",    int'(done),    0);
        check("halt_busy",    int'(busy),    0);
        tick();
        check("halt_ready",       int'(cif.cmd_ready), 1);
        check("halt_aborted_end", int'(aborted),       0);
        check("halt_count_end",   int'(count),         9);

        // Reset mid-run
        issue(OP_LOAD, 4'd8);
        issue(OP_RUN_DOWN, 4'd2);
        tick();
        tick();
        check("midrst_pre_count", int'(count), 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_count",   int'(count),         0);
        check("midrst_ready",   int'(cif.cmd_ready), 1);
        check("midrst_busy",    int'(busy),          0);
        check("midrst_done",    int'(done),          0);
        check("midrst_aborted", int'(aborted),       0);
        tick();
        check("midrst_aborted_next", int'(aborted), 0);

        // Backpressure: LOAD held during a run is taken in the first IDLE cycle
        issue(OP_LOAD, 4'd0);
        exp_q.push_back(4'd4);
        issue(OP_RUN_UP, 4'd4);
        cif.cmd_valid = 1'b1; cif.cmd_op = OP_LOAD; cif.cmd_data = 4'd11;
        g = 0;
        while (busy && g < 40) begin
            check("bp_ready_busy", int'(cif.cmd_ready), 0);
            tick();
            g++;
        end
        if (g >= 40) check("bp_timeout", int'(busy), 0);
        check("bp_done_ready", int'(cif.cmd_ready), 0);
        check("bp_done_count", int'(count), 4);
        tick();
        check("bp_idle_ready", int'(cif.cmd_ready), 1);
        check("bp_idle_count", int'(count), 4);
        tick();
        cif.cmd_valid = 1'b0;
        check("bp_loaded_count", int'(count), 11);
        tick();
        check("bp_final_count", int'(count), 11);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
